// File: rtl/seg_scroll_rx.sv
// Receive-side checker for the 5-digit scrolling 7-segment display: decodes each
// sampled frame, verifies it is a one-digit shift of the previous one, and rebuilds the message.
module seg_scroll_rx #(
    parameter int MAXLEN = 8
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       en,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic [7:0] D,
    input  logic [7:0] E,
    output logic [3:0] char_code,
    output logic       char_valid,
    output logic       msg_done,
    output logic [3:0] msg_len,
    output logic       shift_err,
    output logic       code_err,
    output logic       ovf_err,
    input  logic [3:0] rd_addr,
    output logic [3:0] rd_data
);

    localparam int         IW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [3:0] MAXL = 4'(MAXLEN);

    typedef enum logic [1:0] {IDLE, ARMED, LOAD, DRAIN} state_t;

    state_t     state, state_nx;
    logic [3:0] len;
    logic [3:0] buffer [0:MAXLEN-1];
    logic [7:0] prev_a, prev_b, prev_c, prev_d;

    logic       all_ok, shift_ok, a_blank, rest_blank, all_blank;
    logic       cap, done, upd_prev, set_shift, set_code, set_ovf;
    logic [3:0] code_a, widx;

    function automatic logic [3:0] seg_code(input logic [7:0] seg);
        case (seg)
            8'h5B:   return 4'd1;
            8'h79:   return 4'd2;
            8'h5E:   return 4'd3;
            8'h40:   return 4'd4;
            8'h77:   return 4'd5;
            8'h3D:   return 4'd6;
            8'h73:   return 4'd7;
            8'h71:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Blank (00) is a legal pattern that decodes to code 0.
    function automatic logic seg_ok(input logic [7:0] seg);
        return (seg == 8'h00) || (seg_code(seg) != 4'd0);
    endfunction

    assign code_a     = seg_code(A);
    assign all_ok     = seg_ok(A) && seg_ok(B) && seg_ok(C) && seg_ok(D) && seg_ok(E);
    assign shift_ok   = (B == prev_a) && (C == prev_b) && (D == prev_c) && (E == prev_d);
    assign a_blank    = (A == 8'h00);
    assign rest_blank = (B == 8'h00) && (C == 8'h00) && (D == 8'h00) && (E == 8'h00);
    assign all_blank  = a_blank && rest_blank;
    assign widx       = (state == ARMED) ? 4'd0 : len;

    always_ff @(posedge ck) begin
        if (rs) state <= IDLE;
        else    state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cap       = 1'b0;
        done      = 1'b0;
        upd_prev  = 1'b0;
        set_shift = 1'b0;
        set_code  = 1'b0;
        set_ovf   = 1'b0;
        if (en) begin
            if (!all_ok) begin
                // A bad pattern overrides everything; a shift mismatch in the same frame is still flagged.
                set_code = 1'b1;
                state_nx = IDLE;
                if ((state == LOAD || state == DRAIN) && !shift_ok) set_shift = 1'b1;
            end else begin
                upd_prev = 1'b1;
                case (state)
                    IDLE: if (all_blank) state_nx = ARMED;
                    ARMED: begin
                        if (!a_blank) begin
                            if (rest_blank) begin
                                cap      = 1'b1;
                                state_nx = LOAD;
                            end else begin
                                set_shift = 1'b1;
                                state_nx  = IDLE;
                            end
                        end
                    end
                    LOAD: begin
                        if (!shift_ok) begin
                            set_shift = 1'b1;
                            state_nx  = IDLE;
                            if (!a_blank && len == MAXL) set_ovf = 1'b1;
                        end else if (a_blank) begin
                            state_nx = DRAIN;
                        end else if (len == MAXL) begin
                            set_ovf  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            cap = 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!shift_ok || !a_blank) begin
                            set_shift = 1'b1;
                            state_nx  = IDLE;
                        end else if (all_blank) begin
                            // The terminating blank frame doubles as the arming frame.
                            done     = 1'b1;
                            state_nx = ARMED;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            len        <= 4'd0;
            char_code  <= 4'd0;
            char_valid <= 1'b0;
            msg_done   <= 1'b0;
            msg_len    <= 4'd0;
            shift_err  <= 1'b0;
            code_err   <= 1'b0;
            ovf_err    <= 1'b0;
            prev_a     <= 8'h00;
            prev_b     <= 8'h00;
            prev_c     <= 8'h00;
            prev_d     <= 8'h00;
            for (int i = 0; i < MAXLEN; i++) buffer[i] <= 4'd0;
        end else begin
            char_valid <= cap;
            msg_done   <= done;
            if (cap) begin
                buffer[widx[IW-1:0]] <= code_a;
                len                  <= widx + 4'd1;
                char_code            <= code_a;
            end
            if (done)      msg_len   <= len;
            if (set_shift) shift_err <= 1'b1;
            if (set_code)  code_err  <= 1'b1;
            if (set_ovf)   ovf_err   <= 1'b1;
            if (upd_prev) begin
                prev_a <= A;
                prev_b <= B;
                prev_c <= C;
                prev_d <= D;
            end
        end
    end

    always_comb begin
        rd_data = 4'd0;
        if (rd_addr < MAXL) rd_data = buffer[rd_addr[IW-1:0]];
    end

endmodule
